// File: rtl/pi_pkg.sv
// Shared types and coordinate helpers for the Keccak pi-step engine.
// Latency: none (package only).
// Backpressure: none (package only).
package pi_pkg;

   localparam int NLANE  = 25;
   localparam int P0_IDX = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_MOVE,
      ST_RESTORE,
      ST_FIN
   } pi_state_e;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
   } xy_t;

   // Sum of two coordinates already in 0..4, reduced mod 5.
   function automatic logic [2:0] add5(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

   function automatic logic [4:0] xy_to_idx(input logic [2:0] x, input logic [2:0] y);
      return 5'(y) * 5'd5 + 5'(x);
   endfunction

   function automatic xy_t idx_to_xy(input logic [4:0] idx);
      xy_t r;
      r.x = 3'(idx % 5'd5);
      r.y = 3'(idx / 5'd5);
      return r;
   endfunction

   // Anchor lane of every pass; (0,0) is a fixed point so (1,0) starts the 24-cycle.
   localparam xy_t P0_XY = idx_to_xy(5'(P0_IDX));

endpackage

// File: rtl/pi_src_map.sv
// Pi geometry: which lane feeds position (cur_x, cur_y) in forward or inverse mode.
// Latency: purely combinational.
// Backpressure: none.
module pi_src_map
   import pi_pkg::*;
(
   input  logic [2:0] cur_x,
   input  logic [2:0] cur_y,
   input  logic       inv,
   output logic [2:0] src_x,
   output logic [2:0] src_y,
   output logic [4:0] src_idx,
   output logic       src_is_p0
);

   logic [2:0] two_x;
   logic [2:0] three_y;

   // Forward source is (x+3y, x); inverse source is (y, 2x+3y), all mod 5.
   always_comb begin
      two_x   = add5(cur_x, cur_x);
      three_y = add5(add5(cur_y, cur_y), cur_y);
      if (inv) begin
         src_x = cur_y;
         src_y = add5(two_x, three_y);
      end else begin
         src_x = add5(cur_x, three_y);
         src_y = cur_x;
      end
      src_idx   = xy_to_idx(src_x, src_y);
      src_is_p0 = (src_x == P0_XY.x) && (src_y == P0_XY.y);
   end

endmodule

// File: rtl/keccak_pi_engine.sv
// In-place Keccak pi on 25 W-bit lanes by cycle-following through one temp lane.
// Latency: load 1 cycle; run 25 cycles per pass, done pulses the cycle after the last pass.
// Backpressure: load/start are accepted only in IDLE and silently dropped otherwise.
module keccak_pi_engine
   import pi_pkg::*;
#(
   parameter int W = 1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [25*W-1:0] line_in,
   input  logic            start,
   input  logic            inv,
   input  logic [4:0]      reps,
   output logic            busy,
   output logic            done,
   output logic [25*W-1:0] state_out
);

   logic [W-1:0] lane_q [NLANE];
   logic [W-1:0] tmp_q;
   xy_t          cur_q;
   logic [4:0]   pass_q;
   logic         inv_q;
   pi_state_e    st_q;
   logic         busy_q;
   logic         done_q;

   logic [4:0]   cur_idx;
   xy_t          cur_d;
   logic [4:0]   src_idx;
   logic         cur_src_is_p0;
   logic [2:0]   nxt_src_x;
   logic [2:0]   nxt_src_y;
   logic [4:0]   nxt_src_idx;
   logic         last_move;
   logic         unused_map;

   assign cur_idx = xy_to_idx(cur_q.x, cur_q.y);

   // Source of the lane currently being overwritten; it becomes the next cur.
   pi_src_map u_map_cur (
      .cur_x     (cur_q.x),
      .cur_y     (cur_q.y),
      .inv       (inv_q),
      .src_x     (cur_d.x),
      .src_y     (cur_d.y),
      .src_idx   (src_idx),
      .src_is_p0 (cur_src_is_p0)
   );

   // Look one step ahead: once the next cur is fed by the anchor, this MOVE is the last.
   pi_src_map u_map_nxt (
      .cur_x     (cur_d.x),
      .cur_y     (cur_d.y),
      .inv       (inv_q),
      .src_x     (nxt_src_x),
      .src_y     (nxt_src_y),
      .src_idx   (nxt_src_idx),
      .src_is_p0 (last_move)
   );

   assign unused_map = ^{cur_src_is_p0, nxt_src_x, nxt_src_y, nxt_src_idx};

   // Control FSM plus lane datapath; busy/done are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NLANE; i++) lane_q[i] <= '0;
         tmp_q  <= '0;
         cur_q  <= P0_XY;
         pass_q <= '0;
         inv_q  <= 1'b0;
         st_q   <= ST_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (load) begin
                  for (int i = 0; i < NLANE; i++) lane_q[i] <= line_in[i*W +: W];
               end else if (start) begin
                  inv_q  <= inv;
                  pass_q <= reps;
                  if (reps != 5'd0) begin
                     st_q   <= ST_SAVE;
                     busy_q <= 1'b1;
                  end else begin
                     st_q   <= ST_FIN;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_SAVE: begin
               tmp_q <= lane_q[P0_IDX];
               cur_q <= P0_XY;
               st_q  <= ST_MOVE;
            end
            ST_MOVE: begin
               lane_q[cur_idx] <= lane_q[src_idx];
               cur_q           <= cur_d;
               if (last_move) st_q <= ST_RESTORE;
            end
            ST_RESTORE: begin
               lane_q[cur_idx] <= tmp_q;
               pass_q          <= pass_q - 5'd1;
               if (pass_q == 5'd1) begin
                  st_q   <= ST_FIN;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  st_q <= ST_SAVE;
               end
            end
            ST_FIN: begin
               done_q <= 1'b0;
               st_q   <= ST_IDLE;
            end
            default: begin
               st_q   <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Flatten the lane array with lane idx at bits [idx*W +: W].
   always_comb begin
      state_out = '0;
      for (int i = 0; i < NLANE; i++) state_out[i*W +: W] = lane_q[i];
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_keccak_pi_engine.sv
// Bench for keccak_pi_engine: a W=1 and a W=8 instance share clock and reset.
// Expected states come from an independent pi model and are queued at start.
module tb_keccak_pi_engine;

   logic clk;
   logic rst;

   logic         load1, start1, inv1, busy1, done1;
   logic [4:0]   reps1;
   logic [24:0]  line1, so1;

   logic         load8, start8, inv8, busy8, done8;
   logic [4:0]   reps8;
   logic [199:0] line8, so8;

   logic [199:0] model8;
   logic [199:0] exp8 [$];
   logic [24:0]  exp1 [$];

   int tests;
   int fails;

   keccak_pi_engine #(.W(1)) dut1 (
      .clk(clk), .rst(rst), .load(load1), .line_in(line1), .start(start1),
      .inv(inv1), .reps(reps1), .busy(busy1), .done(done1), .state_out(so1)
   );

   keccak_pi_engine #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .load(load8), .line_in(line8), .start(start8),
      .inv(inv8), .reps(reps8), .busy(busy8), .done(done8), .state_out(so8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Independent pi: forward sends A[x][y] to (y, 2x+3y); inverse undoes it.
   function automatic logic [199:0] pi_model(input logic [199:0] s, input bit iv, input int r);
      logic [199:0] a;
      logic [199:0] b;
      a = s;
      b = '0;
      for (int k = 0; k < r; k++) begin
         for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
               if (!iv) b[(5*((2*x+3*y)%5)+y)*8 +: 8] = a[(5*y+x)*8 +: 8];
               else     b[(5*y+x)*8 +: 8] = a[(5*((2*x+3*y)%5)+y)*8 +: 8];
            end
         end
         a = b;
      end
      return a;
   endfunction

   function automatic logic [199:0] rand_state();
      logic [199:0] v;
      for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'($urandom);
      return v;
   endfunction

   task automatic load8_t(input logic [199:0] v);
      @(negedge clk);
      load8 = 1'b1; line8 = v; model8 = v;
      @(negedge clk);
      load8 = 1'b0;
   endtask

   task automatic load1_t(input logic [24:0] v);
      @(negedge clk);
      load1 = 1'b1; line1 = v;
      @(negedge clk);
      load1 = 1'b0;
   endtask

   // Start a W=8 run, queue its expected result, then scramble inv/reps and wait for done.
   task automatic run8(input bit iv, input logic [4:0] r, output int busy_cnt,
                       output int done_at, output logic [199:0] got);
      @(negedge clk);
      start8 = 1'b1; inv8 = iv; reps8 = r;
      model8 = pi_model(model8, iv, int'(r));
      exp8.push_back(model8);
      @(negedge clk);
      start8 = 1'b0; inv8 = ~iv; reps8 = r + 5'd3;
      busy_cnt = 0; done_at = 0; got = '0;
      for (int n = 1; n <= 900; n++) begin
         if (busy8) busy_cnt++;
         if (done8) begin
            done_at = n; got = so8;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run1(input bit iv, input logic [4:0] r, input logic [24:0] expv,
                       output int done_at, output logic [24:0] got);
      @(negedge clk);
      start1 = 1'b1; inv1 = iv; reps1 = r;
      exp1.push_back(expv);
      @(negedge clk);
      start1 = 1'b0; inv1 = ~iv; reps1 = 5'd0;
      done_at = 0; got = '0;
      for (int n = 1; n <= 900; n++) begin
         if (done1) begin
            done_at = n; got = so1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      tests++; if (so8 !== '0)   begin fails++; $display("FAIL reset_state8: got %h want 0", so8); end
      tests++; if (so1 !== '0)   begin fails++; $display("FAIL reset_state1: got %h want 0", so1); end
      tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy8); end
      tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done8); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fwd_bit();
      int d; logic [24:0] got, e;
      load1_t(25'd1 << 1);
      tests++; if (so1 !== (25'd1 << 1)) begin fails++; $display("FAIL load_visible1: got %h want %h", so1, 25'd1 << 1); end
      run1(1'b0, 5'd1, 25'd1 << 10, d, got);
      e = exp1.pop_front();
      tests++; if (d !== 26) begin fails++; $display("FAIL fwd_bit_latency: got %0d want 26", d); end
      tests++; if (got !== e) begin fails++; $display("FAIL fwd_bit_state: got %h want %h", got, e); end
   endtask

   task automatic test_inv_roundtrip();
      int d; logic [24:0] got, e;
      load1_t(25'd1 << 1);
      run1(1'b1, 5'd1, 25'd1 << 6, d, got);
      e = exp1.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL inv_bit_state: got %h want %h", got, e); end
      run1(1'b0, 5'd1, 25'd1 << 1, d, got);
      e = exp1.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL roundtrip_state: got %h want %h", got, e); end
   endtask

   task automatic test_identity24();
      int bc, d; logic [199:0] got, e, v;
      for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'(i);
      load8_t(v);
      run8(1'b0, 5'd24, bc, d, got);
      e = exp8.pop_front();
      tests++; if (got !== v) begin fails++; $display("FAIL id24_state: got %h want %h", got, v); end
      tests++; if (got !== e) begin fails++; $display("FAIL id24_model: got %h want %h", got, e); end
      tests++; if (bc !== 600) begin fails++; $display("FAIL id24_busy_cycles: got %0d want 600", bc); end
      tests++; if (d !== 601) begin fails++; $display("FAIL id24_done_at: got %0d want 601", d); end
      @(negedge clk);
      tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b want 0", done8); end
   endtask

   task automatic test_reps0();
      int bc, d; logic [199:0] got, e, v;
      v = rand_state();
      load8_t(v);
      tests++; if (so8 !== v) begin fails++; $display("FAIL load_visible8: got %h want %h", so8, v); end
      run8(1'b1, 5'd0, bc, d, got);
      e = exp8.pop_front();
      tests++; if (d !== 1) begin fails++; $display("FAIL reps0_done_at: got %0d want 1", d); end
      tests++; if (bc !== 0) begin fails++; $display("FAIL reps0_busy: got %0d want 0", bc); end
      tests++; if (got !== e) begin fails++; $display("FAIL reps0_state: got %h want %h", got, e); end
   endtask

   task automatic test_back_to_back();
      int bc, d; logic [199:0] got, e;
      load8_t(rand_state());
      run8(1'b1, 5'd3, bc, d, got);
      e = exp8.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL b2b_inv3_state: got %h want %h", got, e); end
      tests++; if (d !== 76) begin fails++; $display("FAIL b2b_inv3_done_at: got %0d want 76", d); end
      run8(1'b0, 5'd5, bc, d, got);
      e = exp8.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL b2b_fwd5_state: got %h want %h", got, e); end
      tests++; if (bc !== 125) begin fails++; $display("FAIL b2b_fwd5_busy: got %0d want 125", bc); end
   endtask

   task automatic test_ignore_mid();
      int d; logic [199:0] got, e, v;
      v = rand_state();
      load8_t(v);
      @(negedge clk);
      start8 = 1'b1; inv8 = 1'b0; reps8 = 5'd2;
      model8 = pi_model(v, 1'b0, 2);
      exp8.push_back(model8);
      @(negedge clk);
      start8 = 1'b0;
      d = 0; got = '0;
      for (int n = 1; n <= 200; n++) begin
         if (n == 11) begin
            load8 = 1'b1; start8 = 1'b1; line8 = ~v; reps8 = 5'd1; inv8 = 1'b1;
         end else begin
            load8 = 1'b0; start8 = 1'b0;
         end
         if (done8) begin
            d = n; got = so8;
            break;
         end
         @(negedge clk);
      end
      load8 = 1'b0; start8 = 1'b0;
      e = exp8.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL ignore_mid_state: got %h want %h", got, e); end
      tests++; if (d !== 51) begin fails++; $display("FAIL ignore_mid_done_at: got %0d want 51", d); end
   endtask

   task automatic test_reset_mid();
      int bc, d, seen; logic [199:0] got, e;
      load8_t(rand_state());
      @(negedge clk);
      start8 = 1'b1; inv8 = 1'b0; reps8 = 5'd3;
      exp8.push_back(pi_model(model8, 1'b0, 3));
      @(negedge clk);
      start8 = 1'b0;
      repeat (39) @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (so8 !== '0) begin fails++; $display("FAIL rstmid_state: got %h want 0", so8); end
      tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy8); end
      tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", done8); end
      // The aborted run never produces a result.
      e = exp8.pop_front();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen); end
      load8_t(rand_state());
      run8(1'b0, 5'd3, bc, d, got);
      e = exp8.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL rstmid_fresh_state: got %h want %h", got, e); end
   endtask

   initial begin
      tests = 0; fails = 0;
      load1 = 1'b0; start1 = 1'b0; inv1 = 1'b0; reps1 = '0; line1 = '0;
      load8 = 1'b0; start8 = 1'b0; inv8 = 1'b0; reps8 = '0; line8 = '0;
      model8 = '0;
      test_reset();
      test_fwd_bit();
      test_inv_roundtrip();
      test_identity24();
      test_reps0();
      test_back_to_back();
      test_ignore_mid();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
